// File: rtl/comparador_sequencial.sv
// Sequential magnitude comparator: one shared 2-bit slice compare per cycle,
// MSB slice first, early exit on the first unequal slice, valid/ready on both sides.
module comparador_sequencial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             M,
    output logic             I,
    output logic             busy
);

    localparam int NS = WIDTH / 2;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             m_q, m_d;
    logic             i_q, i_d;

    logic [1:0] slice_a;
    logic [1:0] slice_b;
    logic       m2;
    logic       i2;

    // Single shared slice: mux the idx-th bit pair out of each operand register
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned s = 0; s < NS; s++) begin
            if (idx_q == IW'(s)) begin
                slice_a = ra_q[2*s +: 2];
                slice_b = rb_q[2*s +: 2];
            end
        end
    end

    assign m2 = (slice_a > slice_b);
    assign i2 = (slice_a == slice_b);

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        idx_d   = idx_q;
        m_d     = m_q;
        i_d     = i_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = b;
                    idx_d   = IW'(NS - 1);
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!i2) begin
                    m_d     = m2;
                    i_d     = 1'b0;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    m_d     = 1'b0;
                    i_d     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            idx_q   <= '0;
            m_q     <= 1'b0;
            i_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            idx_q   <= idx_d;
            m_q     <= m_d;
            i_q     <= i_d;
        end
    end

    // Handshake outputs are pure state decodes; no path from in_valid/out_ready
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_SCAN) || (state_q == S_DONE);
    assign M         = m_q;
    assign I         = i_q;

endmodule

// File: tb/tb_comparador_sequencial.sv
// Scoreboard bench for comparador_sequencial (WIDTH=8): directed cases, then
// randomized pairs with random idle gaps and random out_ready backpressure.
module tb_comparador_sequencial;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic       M;
    logic       I;
    logic       busy;

    comparador_sequencial #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .M        (M),
        .I        (I),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         acc_edge;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    mode = 1;  // 0: random out_ready, 1: always ready, 2: never ready
    logic  done_flag = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Number of 2-bit slices examined: MSB-first position of the first
    // differing slice, or all four when the operands are equal.
    function automatic int exp_k(input logic [7:0] x, input logic [7:0] y);
        int hi;
        if (x == y) return 4;
        hi = 0;
        for (int i = 0; i < 8; i++) if (((x ^ y) >> i) & 8'd1) hi = i;
        return 4 - hi / 2;
    endfunction

    // Drive one pair; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] xa, input logic [7:0] xb);
        int    n;
        item_t it;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_in_ready_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            a        = xa;
            b        = xb;
            it.a     = xa;
            it.b     = xb;
            it.acc_edge = cyc + 1;
            q.push_back(it);
            @(negedge clk);
            in_valid = 1'b0;
            a        = $urandom;
            b        = $urandom;
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    task automatic set_mode(input int m);
        @(posedge clk);
        #1 mode = m;
    endtask

    // Monitor: pops the scoreboard when a fresh result appears, checks
    // values and latency, then checks the result stays put under backpressure.
    initial begin : monitor
        item_t cur;
        logic  seen;
        int    em;
        int    ei;
        seen = 1'b0;
        em = 0;
        ei = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
                out_ready = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!seen) begin
                        if (q.size() == 0) begin
                            chk("unexpected_result", 1, 0);
                        end else begin
                            cur = q.pop_front();
                            em  = (cur.a > cur.b) ? 1 : 0;
                            ei  = (cur.a == cur.b) ? 1 : 0;
                            chk($sformatf("M a=%02h b=%02h", cur.a, cur.b), int'(M), em);
                            chk($sformatf("I a=%02h b=%02h", cur.a, cur.b), int'(I), ei);
                            chk($sformatf("latency a=%02h b=%02h", cur.a, cur.b),
                                cyc - cur.acc_edge, exp_k(cur.a, cur.b));
                        end
                        seen = 1'b1;
                    end else begin
                        chk("M_hold", int'(M), em);
                        chk("I_hold", int'(I), ei);
                    end
                end
                case (mode)
                    0:       out_ready = ($urandom_range(0, 1) == 1);
                    1:       out_ready = 1'b1;
                    default: out_ready = 1'b0;
                endcase
                if (out_valid && out_ready) seen = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        if (!done_flag) begin
            $display("FAIL watchdog_timeout actual=running required=finished");
            $fatal(1, "timeout");
        end
    end

    initial begin : stim
        logic [7:0] ra;
        logic [7:0] rb;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #12;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_M", int'(M), 0);
        chk("reset_I", int'(I), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // MSB slice decides in one cycle
        send(8'hC5, 8'h3F);
        chk("c5_busy_after_e0", int'(busy), 1);
        @(negedge clk);
        chk("c5_out_valid_e1", int'(out_valid), 1);
        chk("c5_in_ready_e1", int'(in_ready), 0);
        @(negedge clk);
        chk("c5_in_ready_e2", int'(in_ready), 1);
        chk("c5_out_valid_e2", int'(out_valid), 0);

        send(8'h5A, 8'h5A);
        wait_drain(20);
        send(8'h12, 8'h13);
        wait_drain(20);
        send(8'h13, 8'h12);
        wait_drain(20);

        // Backpressure: result held, new pairs ignored while not in IDLE
        set_mode(2);
        send(8'h80, 8'h7F);
        @(negedge clk);
        chk("bp_out_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a        = 8'h11;
            b        = 8'h22;
            @(negedge clk);
            chk("bp_in_ready_low", int'(in_ready), 0);
            chk("bp_out_valid_held", int'(out_valid), 1);
            chk("bp_M_held", int'(M), 1);
            chk("bp_I_held", int'(I), 0);
        end
        in_valid = 1'b0;
        set_mode(1);
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_no_extra_capture", q.size(), 0);

        // Asynchronous reset between E0+2 and E0+3 of an equal-operand scan
        send(8'h00, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_M", int'(M), 0);
        chk("midrst_I", int'(I), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        send(8'hFF, 8'hFE);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("ff_out_valid_e3", int'(out_valid), 0);
        @(negedge clk);
        chk("ff_out_valid_e4", int'(out_valid), 1);
        chk("ff_M_e4", int'(M), 1);
        chk("ff_I_e4", int'(I), 0);
        wait_drain(20);

        // Randomized pairs, biased towards equal and near-equal operands
        set_mode(0);
        for (int n = 0; n < 3000; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'd1 << $urandom_range(0, 7));
                default: rb = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(ra, rb);
        end
        set_mode(1);
        wait_drain(200);

        done_flag = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
